// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver that assembles LSB-first bytes into a word with sticky flags
module uart_rx_word #(
    parameter int DATA_WIDTH = 32,
    parameter int UART_Nbit  = 8,
    parameter int baudrate   = 9600,
    parameter int clk_freq   = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SerialDataIn,
    input  logic                  clr_rx_flag,
    output logic [UART_Nbit-1:0]  DataRx,
    output logic                  Byte_valid,
    output logic [DATA_WIDTH-1:0] Word_out,
    output logic                  Rx_flag_out,
    output logic                  Overrun_out,
    output logic                  Frame_err_out
);
    localparam int CPB   = clk_freq / baudrate;
    localparam int LANES = DATA_WIDTH / UART_Nbit;
    localparam int CW    = $clog2(CPB + 1);
    localparam int BW    = $clog2(UART_Nbit + 1);
    localparam int LW    = $clog2(LANES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
    localparam logic [BW-1:0] BLAST   = BW'(UART_Nbit - 1);
    localparam logic [LW-1:0] LLAST   = LW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state, state_n;
    logic                    rx_meta, rx_s;
    logic [CW-1:0]           cnt, cnt_n;
    logic [BW-1:0]           bidx, bidx_n;
    logic [UART_Nbit-1:0]    shift, shift_n;
    logic                    stop_ok, stop_bad;
    logic [LW-1:0]           byte_cnt;
    logic [DATA_WIDTH-1:0]   word_buf, word_asm;
    logic                    complete, word_take;

    // two-flop synchronizer for the asynchronous line, idles high
    always_ff @(posedge clk) begin
        rx_meta <= reset ? 1'b1 : SerialDataIn;
        rx_s    <= reset ? 1'b1 : rx_meta;
    end

    // FSM state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            shift <= shift_n;
        end
    end

    // next-state logic: mid-bit sampling of start, data and stop bits
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        bidx_n   = bidx;
        shift_n  = shift;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n   = '0;
                state_n = rx_s ? IDLE : START;
            end
            START: if (cnt == HALF_M1) begin
                cnt_n   = '0;
                bidx_n  = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == FULL_M1) begin
                cnt_n   = '0;
                shift_n = {rx_s, shift[UART_Nbit-1:1]};
                bidx_n  = (bidx == BLAST) ? bidx : bidx + 1'b1;
                state_n = (bidx == BLAST) ? STOP : DATA;
            end
            STOP: if (cnt == FULL_M1) begin
                cnt_n    = '0;
                stop_ok  = rx_s;
                stop_bad = ~rx_s;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // merge the received byte into its lane and decide whether a finished word is taken
    always_comb begin
        word_asm = word_buf;
        for (int i = 0; i < LANES; i++)
            if (byte_cnt == LW'(i)) word_asm[i*UART_Nbit +: UART_Nbit] = shift;
        complete  = stop_ok & (byte_cnt == LLAST);
        word_take = complete & (~Rx_flag_out | clr_rx_flag);
    end

    // registered outputs, word assembly and sticky flags (events win over clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            DataRx        <= '0;
            Byte_valid    <= 1'b0;
            Word_out      <= '0;
            Rx_flag_out   <= 1'b0;
            Overrun_out   <= 1'b0;
            Frame_err_out <= 1'b0;
            byte_cnt      <= '0;
            word_buf      <= '0;
        end else begin
            Byte_valid <= stop_ok;
            if (stop_ok) begin
                DataRx   <= shift;
                word_buf <= word_asm;
                byte_cnt <= complete ? '0 : byte_cnt + 1'b1;
            end else if (stop_bad) begin
                byte_cnt <= '0;
            end
            if (word_take) Word_out <= word_asm;
            Rx_flag_out   <= word_take | (Rx_flag_out & ~clr_rx_flag);
            Overrun_out   <= (complete & ~word_take) | (Overrun_out & ~clr_rx_flag);
            Frame_err_out <= stop_bad | (Frame_err_out & ~clr_rx_flag);
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed and random 8N1 frames checked against a byte/word-level model
module tb_uart_rx_word;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        SerialDataIn = 1'b1;
    logic        clr_rx_flag = 1'b0;
    logic [7:0]  DataRx;
    logic        Byte_valid;
    logic [31:0] Word_out;
    logic        Rx_flag_out, Overrun_out, Frame_err_out;

    int n_checks = 0;
    int n_errs = 0;
    int bv_seen = 0;

    logic [7:0]  exp_data = '0;
    logic [31:0] exp_word = '0;
    bit          exp_flag = 0, exp_ovr = 0, exp_ferr = 0;
    int          exp_bv = 0;
    logic [7:0]  lanes[$];

    uart_rx_word #(.DATA_WIDTH(32), .UART_Nbit(8), .baudrate(10), .clk_freq(160)) dut (
        .clk(clk), .reset(reset), .SerialDataIn(SerialDataIn), .clr_rx_flag(clr_rx_flag),
        .DataRx(DataRx), .Byte_valid(Byte_valid), .Word_out(Word_out),
        .Rx_flag_out(Rx_flag_out), .Overrun_out(Overrun_out), .Frame_err_out(Frame_err_out)
    );

    always #5 clk = ~clk;

    // counts Byte_valid cycles, sampled on the falling edge
    always @(negedge clk) if (Byte_valid) bv_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"}, 32'(DataRx), 32'(exp_data));
        check({tag, "_word"}, Word_out, exp_word);
        check({tag, "_flag"}, 32'(Rx_flag_out), 32'(exp_flag));
        check({tag, "_ovr"}, 32'(Overrun_out), 32'(exp_ovr));
        check({tag, "_ferr"}, 32'(Frame_err_out), 32'(exp_ferr));
        check({tag, "_bv"}, 32'(Byte_valid), 32'd0);
        check({tag, "_bvcnt"}, 32'(bv_seen), 32'(exp_bv));
    endtask

    task automatic model_frame(input logic [7:0] b, input bit stop, input bit clr);
        bit was = exp_flag;
        if (clr) begin exp_flag = 0; exp_ovr = 0; exp_ferr = 0; end
        if (stop) begin
            exp_data = b;
            exp_bv++;
            lanes.push_back(b);
            if (lanes.size() == 4) begin
                if (!was || clr) begin
                    exp_word = {lanes[3], lanes[2], lanes[1], lanes[0]};
                    exp_flag = 1;
                end else exp_ovr = 1;
                lanes.delete();
            end
        end else begin
            exp_ferr = 1;
            lanes.delete();
        end
    endtask

    task automatic model_reset();
        exp_data = '0; exp_word = '0; exp_flag = 0; exp_ovr = 0; exp_ferr = 0;
        lanes.delete();
    endtask

    task automatic idle(input int n);
        SerialDataIn = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr(input string tag);
        clr_rx_flag = 1'b1;
        @(posedge clk); #1;
        clr_rx_flag = 1'b0;
        exp_flag = 0; exp_ovr = 0; exp_ferr = 0;
        check_all(tag);
    endtask

    // one 160-cycle frame; clr_stop raises clr in the cycle of the stop sample, rst_mid resets in data bit 3
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit clr_stop, input bit rst_mid, input string tag);
        for (int c = 0; c < 160; c++) begin
            SerialDataIn = (c < 16) ? 1'b0 : (c < 144) ? b[(c-16)/16] : stop;
            clr_rx_flag = clr_stop && (c == 154);
            if (rst_mid && c == 72) begin reset = 1'b1; SerialDataIn = 1'b1; end
            @(posedge clk); #1;
            if (rst_mid && c == 72) begin
                reset = 1'b0;
                model_reset();
                check_all({tag, "_rst"});
                return;
            end
        end
        clr_rx_flag = 1'b0;
        model_frame(b, stop, clr_stop);
        check_all(tag);
    endtask

    task automatic send_word(input logic [31:0] w, input bit clr_last, input string tag);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b = w[i*8 +: 8];
            send_frame(b, 1'b1, clr_last && i == 3, 1'b0, tag);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset");
        idle(20);
        send_word(32'h12345678, 0, "assembly");
        for (int c = 0; c < 5; c++) begin SerialDataIn = 1'b0; @(posedge clk); #1; end
        idle(40);
        check_all("glitch");
        pulse_clr("clr1");
        send_frame(8'h11, 1'b1, 0, 0, "ferr_good");
        send_frame(8'hA5, 1'b0, 0, 0, "ferr_bad");
        send_word(32'hDEADBEEF, 0, "after_ferr");
        pulse_clr("clr2");
        send_word(32'h04030201, 0, "ovr_first");
        send_word(32'h08070605, 0, "ovr_second");
        pulse_clr("clr_ovr");
        send_word($urandom, 0, "pre_coinc");
        send_word(32'hCAFEF00D, 1, "coinc");
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b = 8'($urandom);
            bit stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop, 0, 0, "rand");
            if ($urandom_range(0, 3) == 0) pulse_clr("rand_clr");
            idle($urandom_range(0, 20));
        end
        idle(10);
        send_frame(8'h78, 1'b1, 0, 0, "rst_first");
        send_frame(8'h56, 1'b1, 0, 1, "rst_mid");
        idle(40);
        check_all("rst_idle");
        send_word(32'h12345678, 0, "rst_after");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
